// File: rtl/vol_ctrl_stereo.sv
// vol_ctrl_stereo
// Stereo volume controller for the MP3 decoder volume register.
// Buttons are synchronised and debounced. UP and DOWN auto-repeat while they
// are held. MUTE toggles mute on each press. BAL_MODE makes UP/DOWN shift the
// balance between the channels instead of changing the overall volume.
// Each new VOL value is offered once over a REQ/ACK handshake.
//
// Ports:
//   CLK       system clock
//   RST       synchronous, active-high reset
//   UP        async button: louder (attenuation decreases)
//   DOWN      async button: quieter (attenuation increases)
//   MUTE      async button: each press toggles mute
//   BAL_MODE  async switch level: 1 = UP/DOWN adjust balance
//   VOL_ACK   writer has consumed VOL
//   VOL       [15:8] left attenuation, [7:0] right attenuation
//   VOL_REQ   VOL holds a new value awaiting write
//   MUTED     current mute state
module vol_ctrl_stereo #(
  parameter logic [7:0]  STEP         = 8'h10,
  parameter logic [7:0]  MIN_ATT      = 8'h00,
  parameter logic [7:0]  MAX_ATT      = 8'hF0,
  parameter logic [7:0]  RST_ATT      = 8'hF0,
  parameter logic [7:0]  MUTE_ATT     = 8'hFE,
  parameter logic [19:0] DEB_CYCLES   = 20'd500000,
  parameter logic [23:0] REPEAT_DELAY = 24'd5000000,
  parameter logic [23:0] REPEAT_RATE  = 24'd2500000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        UP,
  input  logic        DOWN,
  input  logic        MUTE,
  input  logic        BAL_MODE,
  input  logic        VOL_ACK,
  output logic [15:0] VOL,
  output logic        VOL_REQ,
  output logic        MUTED
);

  // Input index map: 0 = UP, 1 = DOWN, 2 = MUTE, 3 = BAL_MODE
  localparam int N_IN = 4;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WAIT} state_t;

  logic [N_IN-1:0] raw_in;
  logic [N_IN-1:0] deb_lvl;   // debounced levels
  logic [2:0]      rise;      // debounced rising edge (UP, DOWN, MUTE)
  logic [1:0]      evt;       // registered UP/DOWN press-or-repeat events
  logic            both_held;
  logic            mute_evt_reg;

  assign raw_in    = {BAL_MODE, MUTE, DOWN, UP};
  assign both_held = deb_lvl[0] & deb_lvl[1];

  // Synchroniser + debouncer per input. The level follows the synchronised
  // input only after it has disagreed for DEB_CYCLES consecutive cycles.
  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_in
      logic        s1_reg, s2_reg, lvl_reg;
      logic [19:0] cnt_reg;

      always_ff @(posedge CLK) begin
        if (RST) begin
          s1_reg  <= 1'b0;
          s2_reg  <= 1'b0;
          lvl_reg <= 1'b0;
          cnt_reg <= '0;
        end else begin
          s1_reg <= raw_in[gi];
          s2_reg <= s1_reg;
          if (s2_reg != lvl_reg) begin
            if (cnt_reg == DEB_CYCLES - 20'd1) begin
              lvl_reg <= s2_reg;
              cnt_reg <= '0;
            end else begin
              cnt_reg <= cnt_reg + 20'd1;
            end
          end else begin
            cnt_reg <= '0;
          end
        end
      end

      assign deb_lvl[gi] = lvl_reg;

      // BAL_MODE is a level, so only the buttons need edge detection
      if (gi < 3) begin : g_edge
        logic lvl_d_reg;
        always_ff @(posedge CLK) begin
          if (RST) lvl_d_reg <= 1'b0;
          else     lvl_d_reg <= lvl_reg;
        end
        assign rise[gi] = lvl_reg & ~lvl_d_reg;
      end
    end

    // Press / auto-repeat event generators for UP and DOWN. The counter is
    // zero on the cycle the event pulse is visible, so the compare value is
    // the interval minus one.
    for (gi = 0; gi < 2; gi++) begin : g_rep
      logic [23:0] cnt_reg;
      logic        repeating_reg;   // 0 until the first repeat has fired
      logic        evt_reg;

      always_ff @(posedge CLK) begin
        if (RST) begin
          cnt_reg       <= '0;
          repeating_reg <= 1'b0;
          evt_reg       <= 1'b0;
        end else begin
          evt_reg <= 1'b0;
          if (!deb_lvl[gi] || both_held) begin
            cnt_reg       <= '0;
            repeating_reg <= 1'b0;
          end else if (rise[gi]) begin
            evt_reg       <= 1'b1;
            cnt_reg       <= '0;
            repeating_reg <= 1'b0;
          end else if (cnt_reg == (repeating_reg ? REPEAT_RATE : REPEAT_DELAY) - 24'd1) begin
            evt_reg       <= 1'b1;
            cnt_reg       <= '0;
            repeating_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 24'd1;
          end
        end
      end

      assign evt[gi] = evt_reg;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) mute_evt_reg <= 1'b0;
    else     mute_evt_reg <= rise[2];
  end

  // Saturating step helpers; 9-bit intermediates catch carry/borrow
  function automatic logic [7:0] att_inc(input logic [7:0] a);
    logic [8:0] s;
    logic [7:0] r;
    s = {1'b0, a} + {1'b0, STEP};
    r = (s > {1'b0, MAX_ATT}) ? MAX_ATT : s[7:0];
    return r;
  endfunction

  function automatic logic [7:0] att_dec(input logic [7:0] a);
    logic [8:0] s;
    logic [7:0] r;
    s = {1'b0, a} - {1'b0, STEP};
    r = (s[8] || (s[7:0] < MIN_ATT)) ? MIN_ATT : s[7:0];
    return r;
  endfunction

  logic [7:0]  att_l_reg, att_l_next, att_r_reg, att_r_next;
  logic        muted_reg, muted_next;
  logic [15:0] vol_reg, vol_next, eff;
  logic        req_reg, req_next;
  state_t      state_reg, state_next;

  always_comb begin
    att_l_next = att_l_reg;
    att_r_next = att_r_reg;
    muted_next = muted_reg ^ mute_evt_reg;
    // Events are dropped while muted; attenuation is kept for unmute
    if (!muted_reg) begin
      if (evt[0]) begin
        att_l_next = att_dec(att_l_reg);
        att_r_next = deb_lvl[3] ? att_inc(att_r_reg) : att_dec(att_r_reg);
      end else if (evt[1]) begin
        att_l_next = att_inc(att_l_reg);
        att_r_next = deb_lvl[3] ? att_dec(att_r_reg) : att_inc(att_r_reg);
      end
    end
  end

  assign eff = muted_reg ? {MUTE_ATT, MUTE_ATT} : {att_l_reg, att_r_reg};

  // Handshake FSM. Changes arriving during WAIT only move eff; the latest
  // value is picked up from IDLE, which coalesces intermediate steps.
  always_comb begin
    state_next = state_reg;
    vol_next   = vol_reg;
    req_next   = req_reg;
    unique case (state_reg)
      ST_INIT: begin
        vol_next   = eff;
        req_next   = 1'b1;
        state_next = ST_WAIT;
      end
      ST_IDLE: begin
        if (eff != vol_reg) begin
          vol_next   = eff;
          req_next   = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (VOL_ACK) begin
          req_next   = 1'b0;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      att_l_reg <= RST_ATT;
      att_r_reg <= RST_ATT;
      muted_reg <= 1'b0;
      vol_reg   <= {RST_ATT, RST_ATT};
      req_reg   <= 1'b0;
      state_reg <= ST_INIT;
    end else begin
      att_l_reg <= att_l_next;
      att_r_reg <= att_r_next;
      muted_reg <= muted_next;
      vol_reg   <= vol_next;
      req_reg   <= req_next;
      state_reg <= state_next;
    end
  end

  assign VOL     = vol_reg;
  assign VOL_REQ = req_reg;
  assign MUTED   = muted_reg;

endmodule

// File: tb/tb_vol_ctrl_stereo.sv
// Directed bench for vol_ctrl_stereo with short debounce/repeat timing.
// An ACK responder answers each request a couple of cycles after it appears
// (can be disabled to hold the handshake open). A monitor logs every new
// request and checks VOL stays put while a request is outstanding.
module tb_vol_ctrl_stereo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        up = 1'b0, down = 1'b0, mute = 1'b0, bal = 1'b0, ack = 1'b0;
  logic [15:0] vol;
  logic        vol_req, muted;

  int          n_asserts = 0;
  int          n_fail    = 0;
  int          req_count = 0;
  logic [15:0] req_log[$];
  logic        req_prev = 1'b0;
  logic [15:0] vol_prev = 16'h0;
  bit          ack_en   = 1'b1;
  int          req_age  = 0;

  always #5 clk = ~clk;

  vol_ctrl_stereo #(
    .DEB_CYCLES  (20'd4),
    .REPEAT_DELAY(24'd16),
    .REPEAT_RATE (24'd8)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .UP      (up),
    .DOWN    (down),
    .MUTE    (mute),
    .BAL_MODE(bal),
    .VOL_ACK (ack),
    .VOL     (vol),
    .VOL_REQ (vol_req),
    .MUTED   (muted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // which: 0 = UP, 1 = DOWN, 2 = MUTE
  task automatic pulse(input int which, input int hold);
    case (which)
      0: up = 1'b1;
      1: down = 1'b1;
      default: mute = 1'b1;
    endcase
    cycles(hold);
    up = 1'b0;
    down = 1'b0;
    mute = 1'b0;
    cycles(20);
  endtask

  // ACK responder
  initial begin
    forever begin
      @(negedge clk);
      if (ack) begin
        ack = 1'b0;
        req_age = 0;
      end else if (ack_en && vol_req) begin
        if (req_age >= 2) ack = 1'b1;
        else req_age++;
      end else begin
        req_age = 0;
      end
    end
  end

  // Request monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (vol_req && req_prev) check("vol_stable", vol, vol_prev);
        if (vol_req && !req_prev) begin
          req_count++;
          req_log.push_back(vol);
          $display("req %0d: VOL=%h MUTED=%0b", req_count, vol, muted);
        end
      end
      req_prev = vol_req;
      vol_prev = vol;
    end
  end

  initial begin
    int base;
    int base_idx;
    logic [15:0] e;

    // 1. Reset and the initial request
    cycles(5);
    check("rst_vol", vol, 16'hF0F0);
    check("rst_req", vol_req, 1'b0);
    check("rst_muted", muted, 1'b0);
    rst = 1'b0;
    cycles(1);
    check("init_req", vol_req, 1'b1);
    check("init_vol", vol, 16'hF0F0);
    cycles(10);
    check("init_ack_req", vol_req, 1'b0);
    check("init_req_count", req_count, 1);

    // 2. Glitch rejected, clean press accepted
    up = 1'b1;
    cycles(3);
    up = 1'b0;
    cycles(20);
    check("glitch_vol", vol, 16'hF0F0);
    check("glitch_reqs", req_count, 1);
    pulse(0, 10);
    check("up_vol", vol, 16'hE0E0);
    check("up_reqs", req_count, 2);

    // 3. Auto-repeat: 60-cycle hold gives press + 6 repeats
    base = req_count;
    base_idx = req_log.size();
    pulse(0, 60);
    check("rep_reqs", req_count - base, 7);
    check("rep_vol", vol, 16'h7070);
    e = 16'hE0E0;
    for (int k = base_idx; k < req_log.size(); k++) begin
      e = e - 16'h1010;
      check("rep_step", req_log[k], e);
    end
    // Long hold saturates at 0000 without wrapping
    base = req_count;
    base_idx = req_log.size();
    pulse(0, 200);
    check("sat_reqs", req_count - base, 7);
    check("sat_vol", vol, 16'h0000);
    e = 16'h7070;
    for (int k = base_idx; k < req_log.size(); k++) begin
      e = e - 16'h1010;
      check("sat_step", req_log[k], e);
    end

    // 4. Balance mode
    for (int k = 0; k < 8; k++) pulse(1, 10);
    check("to_8080", vol, 16'h8080);
    bal = 1'b1;
    cycles(10);
    for (int k = 0; k < 3; k++) pulse(0, 10);
    check("bal_up_vol", vol, 16'h50B0);
    base = req_count;
    for (int k = 0; k < 12; k++) pulse(1, 10);
    check("bal_dn_vol", vol, 16'hF000);
    check("bal_dn_reqs", req_count - base, 11);
    bal = 1'b0;
    cycles(10);
    pulse(1, 200);
    check("max_vol", vol, 16'hF0F0);
    base = req_count;
    pulse(1, 10);
    check("max_hold_vol", vol, 16'hF0F0);
    check("max_no_req", req_count - base, 0);
    for (int k = 0; k < 9; k++) pulse(0, 10);
    check("to_6060", vol, 16'h6060);

    // 5. Mute
    pulse(2, 10);
    check("mute_vol", vol, 16'hFEFE);
    check("mute_on", muted, 1'b1);
    base = req_count;
    pulse(0, 10);
    check("mute_up_vol", vol, 16'hFEFE);
    check("mute_up_reqs", req_count - base, 0);
    pulse(2, 10);
    check("unmute_vol", vol, 16'h6060);
    check("mute_off", muted, 1'b0);

    // 6. Coalescing while the writer stalls
    for (int k = 0; k < 4; k++) pulse(1, 10);
    check("to_a0a0", vol, 16'hA0A0);
    ack_en = 1'b0;
    base = req_count;
    for (int k = 0; k < 3; k++) pulse(1, 10);
    check("frozen_vol", vol, 16'hB0B0);
    check("frozen_req", vol_req, 1'b1);
    check("frozen_reqs", req_count - base, 1);
    ack_en = 1'b1;
    cycles(20);
    check("coalesced_vol", vol, 16'hD0D0);
    check("coalesced_reqs", req_count - base, 2);
    check("coalesced_req_low", vol_req, 1'b0);
    base = req_count;
    up = 1'b1;
    down = 1'b1;
    cycles(60);
    up = 1'b0;
    down = 1'b0;
    cycles(20);
    check("both_vol", vol, 16'hD0D0);
    check("both_reqs", req_count - base, 0);

    // 7. Reset mid-handshake
    ack_en = 1'b0;
    pulse(1, 10);
    check("mid_req", vol_req, 1'b1);
    check("mid_vol", vol, 16'hE0E0);
    rst = 1'b1;
    cycles(2);
    check("mid_rst_vol", vol, 16'hF0F0);
    check("mid_rst_req", vol_req, 1'b0);
    rst = 1'b0;
    cycles(1);
    check("mid_init_req", vol_req, 1'b1);
    check("mid_init_vol", vol, 16'hF0F0);
    ack_en = 1'b1;
    cycles(10);
    check("mid_done_req", vol_req, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
